// File: rtl/hid_kbd_pkg.sv
// Shared HID boot-keyboard definitions: register map, modifier masks, scancodes and the
// ASCII-to-scancode lookup (inverse of the host-side scancode2char).
package hid_kbd_pkg;

    localparam logic [7:0] REG_DATA  = 8'h00;
    localparam logic [7:0] REG_COUNT = 8'h01;
    localparam logic [7:0] REG_CTRL  = 8'h02;
    localparam logic [7:0] REG_DROP  = 8'h03;

    localparam logic [7:0] SHIFT_MASK = 8'h22;
    localparam logic [7:0] CTRL_MASK  = 8'h11;
    localparam logic [7:0] LSHIFT     = 8'h02;
    localparam logic [7:0] LCTRL      = 8'h01;
    localparam logic [7:0] MOD_NONE   = 8'h00;

    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_1     = 8'h1E;
    localparam logic [7:0] KEY_0     = 8'h27;
    localparam logic [7:0] KEY_ENTER = 8'h28;
    localparam logic [7:0] KEY_ESC   = 8'h29;
    localparam logic [7:0] KEY_BKSP  = 8'h2A;
    localparam logic [7:0] KEY_TAB   = 8'h2B;
    localparam logic [7:0] KEY_SPACE = 8'h2C;
    localparam logic [7:0] KEY_RIGHT = 8'h4F;
    localparam logic [7:0] KEY_LEFT  = 8'h50;
    localparam logic [7:0] KEY_DOWN  = 8'h51;
    localparam logic [7:0] KEY_UP    = 8'h52;

    typedef struct packed {
        logic       valid;
        logic [7:0] mod;
        logic [7:0] code;
    } scan_t;

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StPress,
        StGap1,
        StRelease,
        StGap2
    } state_e;

    function automatic scan_t char2scancode(input logic [7:0] ch);
        scan_t s;
        s       = '0;
        s.valid = 1'b1;
        if (ch >= 8'h61 && ch <= 8'h7A) begin
            s.code = ch - 8'h61 + KEY_A;
        end else if (ch >= 8'h41 && ch <= 8'h5A) begin
            s.mod  = LSHIFT;
            s.code = ch - 8'h41 + KEY_A;
        end else if (ch == 8'h08) begin
            s.code = KEY_BKSP;
        end else if (ch == 8'h09) begin
            s.code = KEY_TAB;
        end else if (ch == 8'h0D) begin
            s.code = KEY_ENTER;
        end else if (ch >= 8'h01 && ch <= 8'h1A) begin
            s.mod  = LCTRL;
            s.code = ch - 8'h01 + KEY_A;
        end else if (ch >= 8'h31 && ch <= 8'h39) begin
            s.code = ch - 8'h31 + KEY_1;
        end else begin
            // '#' resolves to the unshifted non-US hash key (32), the first table match
            case (ch)
                8'h30: s.code = KEY_0;
                8'h1B: s.code = KEY_ESC;
                8'h20: s.code = KEY_SPACE;
                8'h2D: s.code = 8'h2D;
                8'h3D: s.code = 8'h2E;
                8'h5B: s.code = 8'h2F;
                8'h5D: s.code = 8'h30;
                8'h5C: s.code = 8'h31;
                8'h23: s.code = 8'h32;
                8'h3B: s.code = 8'h33;
                8'h27: s.code = 8'h34;
                8'h60: s.code = 8'h35;
                8'h2C: s.code = 8'h36;
                8'h2E: s.code = 8'h37;
                8'h2F: s.code = 8'h38;
                8'h21: begin s.mod = LSHIFT; s.code = 8'h1E; end
                8'h40: begin s.mod = LSHIFT; s.code = 8'h1F; end
                8'h24: begin s.mod = LSHIFT; s.code = 8'h21; end
                8'h25: begin s.mod = LSHIFT; s.code = 8'h22; end
                8'h5E: begin s.mod = LSHIFT; s.code = 8'h23; end
                8'h26: begin s.mod = LSHIFT; s.code = 8'h24; end
                8'h2A: begin s.mod = LSHIFT; s.code = 8'h25; end
                8'h28: begin s.mod = LSHIFT; s.code = 8'h26; end
                8'h29: begin s.mod = LSHIFT; s.code = 8'h27; end
                8'h5F: begin s.mod = LSHIFT; s.code = 8'h2D; end
                8'h2B: begin s.mod = LSHIFT; s.code = 8'h2E; end
                8'h7B: begin s.mod = LSHIFT; s.code = 8'h2F; end
                8'h7D: begin s.mod = LSHIFT; s.code = 8'h30; end
                8'h7C: begin s.mod = LSHIFT; s.code = 8'h31; end
                8'h3A: begin s.mod = LSHIFT; s.code = 8'h33; end
                8'h22: begin s.mod = LSHIFT; s.code = 8'h34; end
                8'h7E: begin s.mod = LSHIFT; s.code = 8'h35; end
                8'h3C: begin s.mod = LSHIFT; s.code = 8'h36; end
                8'h3E: begin s.mod = LSHIFT; s.code = 8'h37; end
                8'h3F: begin s.mod = LSHIFT; s.code = 8'h38; end
                8'h89: s.code = KEY_RIGHT;
                8'h88: s.code = KEY_LEFT;
                8'h8A: s.code = KEY_DOWN;
                8'h8B: s.code = KEY_UP;
                default: s = '0;
            endcase
        end
        return s;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with flush; flush wins over a same-cycle push or pop.
module sync_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    // A push into a full FIFO still lands if a pop frees a slot in the same cycle
    assign do_pop  = pop & ~empty & ~flush;
    assign do_push = push & (~full | do_pop) & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (do_push && !do_pop)      count_q <= count_q + (AW+1)'(1);
            else if (do_pop && !do_push) count_q <= count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/hid_report_encoder.sv
// ASCII-to-HID boot keyboard encoder: CPU-written ASCII FIFO drained into 8-byte press/release
// reports on a valid/ready byte stream, with an idle gap after each report.
module hid_report_encoder
    import hid_kbd_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned GAP_CYCLES = 16
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       cs_i,
    input  logic       R_W_n,
    input  logic [7:0] reg_addr_i,
    input  logic [7:0] data_i,
    output logic [7:0] data_o,
    output logic [7:0] rpt_data_o,
    output logic       rpt_valid_o,
    input  logic       rpt_ready_i,
    output logic       rpt_last_o,
    output logic       busy_o
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned GW = $clog2(GAP_CYCLES + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    logic          wr_en, push_req, ctrl_wr, flush_req, ovf_clr, pop_req, ovf_set;
    logic [7:0]    fifo_rdata;
    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    scan_t         head_scan;

    state_e        state_q;
    scan_t         scan_q;
    logic [2:0]    idx_q;
    logic [GW-1:0] gap_q;
    logic [7:0]    drop_cnt_q;
    logic          overflow_q;
    logic [7:0]    rpt_data_q;
    logic          rpt_valid_q, rpt_last_q;

    assign wr_en     = cs_i & ~R_W_n;
    assign push_req  = wr_en & (reg_addr_i == REG_DATA);
    assign ctrl_wr   = wr_en & (reg_addr_i == REG_CTRL);
    assign flush_req = ctrl_wr & data_i[1];
    assign ovf_clr   = ctrl_wr & data_i[0];
    assign pop_req   = (state_q == StIdle) & ~fifo_empty & ~flush_req;
    assign ovf_set   = push_req & fifo_full & ~pop_req & ~flush_req;
    assign head_scan = char2scancode(fifo_rdata);

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk_i),
        .rst_n (rst_n_i),
        .push  (push_req),
        .wdata (data_i),
        .pop   (pop_req),
        .flush (flush_req),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        data_o = 8'h00;
        if (cs_i && R_W_n) begin
            unique case (reg_addr_i)
                REG_DATA:  data_o = {5'b0, overflow_q, fifo_full, fifo_empty};
                REG_COUNT: data_o[CW-1:0] = fifo_count;
                REG_DROP:  data_o = drop_cnt_q;
                default:   data_o = 8'h00;
            endcase
        end
    end

    // Set wins over a same-cycle clear so no overflow event is lost
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            overflow_q <= 1'b0;
        end else if (ovf_set) begin
            overflow_q <= 1'b1;
        end else if (ovf_clr) begin
            overflow_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= StIdle;
            scan_q      <= '0;
            idx_q       <= '0;
            gap_q       <= '0;
            drop_cnt_q  <= '0;
            rpt_data_q  <= '0;
            rpt_valid_q <= 1'b0;
            rpt_last_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (pop_req) begin
                        scan_q  <= head_scan;
                        state_q <= StLookup;
                    end
                end
                StLookup: begin
                    if (scan_q.valid) begin
                        state_q     <= StPress;
                        idx_q       <= '0;
                        rpt_valid_q <= 1'b1;
                        rpt_data_q  <= scan_q.mod;
                        rpt_last_q  <= 1'b0;
                    end else begin
                        state_q <= StIdle;
                        if (drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
                    end
                end
                StPress, StRelease: begin
                    if (rpt_ready_i) begin
                        if (idx_q == 3'd7) begin
                            rpt_valid_q <= 1'b0;
                            rpt_data_q  <= 8'h00;
                            rpt_last_q  <= 1'b0;
                            gap_q       <= '0;
                            state_q     <= (state_q == StPress) ? StGap1 : StGap2;
                        end else begin
                            idx_q      <= idx_q + 3'd1;
                            // Byte 2 of the press report carries the keycode
                            rpt_data_q <= (state_q == StPress && idx_q == 3'd1) ? scan_q.code
                                                                                 : 8'h00;
                            rpt_last_q <= (idx_q == 3'd6);
                        end
                    end
                end
                StGap1, StGap2: begin
                    if (gap_q == GAP_LAST) begin
                        if (state_q == StGap1) begin
                            state_q     <= StRelease;
                            idx_q       <= '0;
                            rpt_valid_q <= 1'b1;
                            rpt_data_q  <= 8'h00;
                            rpt_last_q  <= 1'b0;
                        end else begin
                            state_q <= StIdle;
                        end
                    end else begin
                        gap_q <= gap_q + GW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign rpt_data_o  = rpt_data_q;
    assign rpt_valid_o = rpt_valid_q;
    assign rpt_last_o  = rpt_last_q;
    assign busy_o      = (state_q != StIdle) | ~fifo_empty;

endmodule

// File: tb/tb_hid_report_encoder.sv
// Bench for hid_report_encoder: directed steps plus random characters checked against a
// keyboard-layout reference model and a queue of expected report bytes.
module tb_hid_report_encoder;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned GAP   = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cs, rw;
    logic [7:0] addr, wdata, rdata;
    logic [7:0] rpt_data;
    logic       rpt_valid, ready, rpt_last, busy;

    int total = 0;
    int bad   = 0;
    int exp_drops = 0;
    logic [8:0] rx_q[$];
    logic [8:0] exp_q[$];

    hid_report_encoder #(
        .FIFO_DEPTH (DEPTH),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .cs_i        (cs),
        .R_W_n       (rw),
        .reg_addr_i  (addr),
        .data_i      (wdata),
        .data_o      (rdata),
        .rpt_data_o  (rpt_data),
        .rpt_valid_o (rpt_valid),
        .rpt_ready_i (ready),
        .rpt_last_o  (rpt_last),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    // Inputs change 2ns after posedge, so the negedge sees what the next posedge will take
    always @(negedge clk) begin
        if (rst_n && rpt_valid && ready) rx_q.push_back({rpt_last, rpt_data});
    end

    function automatic logic [16:0] ref_map(input logic [7:0] c);
        logic [7:0] unsh [12];
        logic [7:0] shf  [11];
        logic [7:0] base [11];
        string sym  = "!@#$%^&*()";
        string dig  = "1234567890";
        unsh = '{8'h2D, 8'h3D, 8'h5B, 8'h5D, 8'h5C, 8'h23, 8'h3B, 8'h27, 8'h60, 8'h2C, 8'h2E,
                 8'h2F};
        shf  = '{8'h5F, 8'h2B, 8'h7B, 8'h7D, 8'h7C, 8'h3A, 8'h22, 8'h3C, 8'h3E, 8'h3F, 8'h7E};
        base = '{8'h2D, 8'h3D, 8'h5B, 8'h5D, 8'h5C, 8'h3B, 8'h27, 8'h2C, 8'h2E, 8'h2F, 8'h60};
        if (c == 8'h08) return {1'b1, 8'h00, 8'h2A};
        if (c == 8'h09) return {1'b1, 8'h00, 8'h2B};
        if (c == 8'h0D) return {1'b1, 8'h00, 8'h28};
        if (c == 8'h1B) return {1'b1, 8'h00, 8'h29};
        if (c == 8'h20) return {1'b1, 8'h00, 8'h2C};
        if (c >= 8'h01 && c <= 8'h1A) return {1'b1, 8'h01, 8'(c + 8'h03)};
        if (c >= 8'h61 && c <= 8'h7A) return {1'b1, 8'h00, 8'(c - 8'h61 + 8'h04)};
        if (c >= 8'h41 && c <= 8'h5A) return {1'b1, 8'h02, 8'(c - 8'h41 + 8'h04)};
        for (int i = 0; i < dig.len(); i++)
            if (dig[i] == c) return {1'b1, 8'h00, 8'(8'h1E + i)};
        for (int i = 0; i < 12; i++)
            if (unsh[i] == c) return {1'b1, 8'h00, 8'(8'h2D + i)};
        for (int i = 0; i < sym.len(); i++)
            if (sym[i] == c) return {1'b1, 8'h02, 8'(8'h1E + i)};
        for (int i = 0; i < 11; i++)
            if (shf[i] == c)
                for (int j = 0; j < 12; j++)
                    if (unsh[j] == base[i]) return {1'b1, 8'h02, 8'(8'h2D + j)};
        case (c)
            8'h89: return {1'b1, 8'h00, 8'h4F};
            8'h88: return {1'b1, 8'h00, 8'h50};
            8'h8A: return {1'b1, 8'h00, 8'h51};
            8'h8B: return {1'b1, 8'h00, 8'h52};
            default: return 17'h0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        cs = 1'b1; rw = 1'b0; addr = a; wdata = d;
        tick(1);
        cs = 1'b0; rw = 1'b1;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
        cs = 1'b1; rw = 1'b1; addr = a;
        #1;
        d = rdata;
        cs = 1'b0;
    endtask

    task automatic expect_char(input logic [7:0] c);
        logic [16:0] m;
        logic [7:0]  b;
        m = ref_map(c);
        if (!m[16]) begin
            if (exp_drops < 255) exp_drops++;
        end else begin
            for (int i = 0; i < 16; i++) begin
                b = (i == 0) ? m[15:8] : (i == 2) ? m[7:0] : 8'h00;
                exp_q.push_back({(i % 8) == 7, b});
            end
        end
    endtask

    task automatic check_stream(input string tag);
        check({tag, "_len"}, 32'(rx_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            check({tag, "_byte"}, 32'(rx_q[i]), 32'(exp_q[i]));
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic wait_idle(input string tag, input bit rnd);
        int n = 0;
        while (busy && n < 3000) begin
            if (rnd) ready = ($urandom_range(0, 3) != 0);
            tick(1);
            n++;
        end
        ready = 1'b1;
        tick(1);
        check({tag, "_idle"}, 32'(busy), 32'(0));
    endtask

    task automatic wait_valid(input logic lvl, input string tag);
        int n = 0;
        while (rpt_valid !== lvl && n < 200) begin
            tick(1);
            n++;
        end
        check(tag, 32'(rpt_valid), 32'(lvl));
    endtask

    logic [7:0] rd;
    logic [7:0] ch;
    logic [7:0] chars[10];
    int         n, gap;

    initial begin
        cs = 1'b0; rw = 1'b1; addr = '0; wdata = '0; ready = 1'b1; rst_n = 1'b0;
        tick(3);
        check("rst_valid", 32'(rpt_valid), 32'(0));
        check("rst_data", 32'(rpt_data), 32'(0));
        check("rst_last", 32'(rpt_last), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        rst_n = 1'b1;
        tick(1);
        bus_read(8'h00, rd); check("rst_reg00", 32'(rd), 32'h01);
        bus_read(8'h01, rd); check("rst_reg01", 32'(rd), 32'h00);
        bus_read(8'h03, rd); check("rst_reg03", 32'(rd), 32'h00);

        // 'a': latency, gap length, full stream
        bus_write(8'h00, 8'h61);
        expect_char(8'h61);
        check("t1_busy", 32'(busy), 32'(1));
        tick(1); check("t1_lat_n1", 32'(rpt_valid), 32'(0));
        tick(1); check("t1_lat_n2", 32'(rpt_valid), 32'(1));
        check("t1_mod", 32'(rpt_data), 32'h00);
        n = 0;
        while (!(rpt_valid && rpt_last) && n < 100) begin tick(1); n++; end
        check("t1_last", 32'(rpt_valid && rpt_last), 32'(1));
        gap = 0;
        tick(1);
        while (!rpt_valid && gap < 100) begin gap++; tick(1); end
        check("t1_gap", 32'(gap), 32'(GAP));
        wait_idle("t1", 1'b0);
        check_stream("t1");

        // 'A' then '!'
        bus_write(8'h00, 8'h41); expect_char(8'h41);
        bus_write(8'h00, 8'h21); expect_char(8'h21);
        wait_idle("t2", 1'b0);
        check_stream("t2");

        // back-pressure held mid-press on the keycode byte
        bus_write(8'h00, 8'h63); expect_char(8'h63);
        wait_valid(1'b1, "t3_valid");
        tick(2);
        ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            check("t3_hold_valid", 32'(rpt_valid), 32'(1));
            check("t3_hold_data", 32'(rpt_data), 32'h06);
            check("t3_hold_last", 32'(rpt_last), 32'(0));
        end
        ready = 1'b1;
        wait_idle("t3", 1'b0);
        check_stream("t3");

        // overflow: 10 writes with the sink stalled
        ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            do ch = 8'($urandom_range(0, 255)); while (!ref_map(ch)[16]);
            chars[i] = ch;
            bus_write(8'h00, ch);
        end
        for (int i = 0; i < 9; i++) expect_char(chars[i]);
        bus_read(8'h00, rd); check("t4_reg00_ovf", 32'(rd), 32'h06);
        bus_read(8'h01, rd); check("t4_reg01", 32'(rd), 32'(DEPTH));
        bus_write(8'h02, 8'h01);
        bus_read(8'h00, rd); check("t4_reg00_clr", 32'(rd), 32'h02);
        wait_idle("t4", 1'b1);
        check_stream("t4");

        // unmappable byte is counted and produces nothing
        bus_write(8'h00, 8'h80); expect_char(8'h80);
        bus_write(8'h00, 8'h62); expect_char(8'h62);
        wait_idle("t5", 1'b0);
        bus_read(8'h03, rd); check("t5_drop", 32'(rd), 32'(exp_drops));
        check_stream("t5");

        // random bytes, random back-pressure
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 5; i++) begin
                ch = 8'($urandom_range(0, 255));
                bus_write(8'h00, ch);
                expect_char(ch);
            end
            wait_idle("rnd", 1'b1);
            bus_read(8'h03, rd); check("rnd_drop", 32'(rd), 32'(exp_drops));
            check_stream("rnd");
        end

        // drop counter saturates
        for (int i = 0; i < 260; i++) begin
            bus_write(8'h00, 8'h00);
            expect_char(8'h00);
            tick(2);
        end
        wait_idle("sat", 1'b0);
        bus_read(8'h03, rd); check("sat_drop", 32'(rd), 32'hFF);
        check_stream("sat");

        // flush during press: in-flight pair completes, queued chars vanish
        bus_write(8'h00, 8'h78); expect_char(8'h78);
        bus_write(8'h00, 8'h79);
        bus_write(8'h00, 8'h7A);
        bus_write(8'h00, 8'h77);
        check("t6_in_press", 32'(rpt_valid), 32'(1));
        bus_write(8'h02, 8'h02);
        bus_read(8'h01, rd); check("t6_reg01", 32'(rd), 32'h00);
        wait_idle("t6", 1'b0);
        check_stream("t6");

        // asynchronous reset mid-release
        bus_write(8'h00, 8'h71);
        wait_valid(1'b1, "t6_press");
        wait_valid(1'b0, "t6_gap");
        wait_valid(1'b1, "t6_release");
        tick(2);
        check("t6_pre_rst", 32'(rpt_valid), 32'(1));
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 32'(rpt_valid), 32'(0));
        check("t6_rst_data", 32'(rpt_data), 32'(0));
        check("t6_rst_busy", 32'(busy), 32'(0));
        bus_read(8'h00, rd); check("t6_rst_reg00", 32'(rd), 32'h01);
        bus_read(8'h01, rd); check("t6_rst_reg01", 32'(rd), 32'h00);
        bus_read(8'h02, rd); check("t6_rst_reg02", 32'(rd), 32'h00);
        bus_read(8'h03, rd); check("t6_rst_reg03", 32'(rd), 32'h00);
        tick(2);
        rst_n = 1'b1;
        rx_q.delete();
        exp_q.delete();
        exp_drops = 0;
        tick(1);

        bus_write(8'h00, 8'h7A); expect_char(8'h7A);
        wait_idle("post", 1'b0);
        check_stream("post");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
